// File: rtl/ifft_stage3_serializer_pkg.sv
// Shared constants for the IFFT stage-3 serializer: word width, twiddle, shifts, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ifft_stage3_serializer_pkg;

  // Default real/imag word width (matches the core instruction width).
  localparam int INST_WIDTH = 32;

  // cos(pi/4) in Q8: 0.7071 * 256 rounded.
  localparam int TW_C = 181;

  // Fixed-point scale of the twiddle products.
  localparam int Q_SHIFT = 8;

  // 1/8 normalisation of the 8-point inverse transform.
  localparam int N_SHIFT = 3;

  // Headroom bits added to the word width for the butterfly intermediates.
  localparam int GUARD_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/ifft_stage3_serializer_bfly_pair.sv
// Inverse radix-2 butterfly pair with conjugate twiddle and 1/8 normalisation.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   i_a_re/i_a_im   top input a (position p)
//   i_b_re/i_b_im   bottom input b (position p+4)
//   i_tw_sel        twiddle index p: 0 -> 1, 1 -> (1+j)/sqrt2, 2 -> j, 3 -> (-1+j)/sqrt2
//   o_top_*         ((a + w*b) truncated) >>> 3
//   o_bot_*         ((a - w*b) truncated) >>> 3
module ifft_bfly_pair
  import ifft_stage3_serializer_pkg::*;
#(
  parameter int DATA_W = INST_WIDTH
) (
  input  logic signed [DATA_W-1:0] i_a_re,
  input  logic signed [DATA_W-1:0] i_a_im,
  input  logic signed [DATA_W-1:0] i_b_re,
  input  logic signed [DATA_W-1:0] i_b_im,
  input  logic        [1:0]        i_tw_sel,
  output logic signed [DATA_W-1:0] o_top_re,
  output logic signed [DATA_W-1:0] o_top_im,
  output logic signed [DATA_W-1:0] o_bot_re,
  output logic signed [DATA_W-1:0] o_bot_im
);

  localparam int IW = DATA_W + GUARD_W;
  localparam logic signed [IW-1:0] W_C   = IW'(TW_C);
  localparam logic signed [IW-1:0] W_RND = IW'((1 << Q_SHIFT) - 1);

  logic signed [IW-1:0] w_ar, w_ai, w_br, w_bi;
  logic signed [IW-1:0] w_brc, w_bic;
  logic signed [IW-1:0] w_wr, w_wi;

  // Sign-extend into the wide intermediate domain.
  assign w_ar  = IW'(i_a_re);
  assign w_ai  = IW'(i_a_im);
  assign w_br  = IW'(i_b_re);
  assign w_bi  = IW'(i_b_im);
  assign w_brc = w_br * W_C;
  assign w_bic = w_bi * W_C;

  // w*b at x256 scale; unit-magnitude twiddles are exact shifts.
  always_comb begin
    w_wr = '0;
    w_wi = '0;
    case (i_tw_sel)
      2'd0: begin
        w_wr = w_br <<< Q_SHIFT;
        w_wi = w_bi <<< Q_SHIFT;
      end
      2'd1: begin
        w_wr = w_brc - w_bic;
        w_wi = w_bic + w_brc;
      end
      2'd2: begin
        w_wr = -(w_bi <<< Q_SHIFT);
        w_wi = w_br <<< Q_SHIFT;
      end
      default: begin
        w_wr = -w_brc - w_bic;
        w_wi = w_brc - w_bic;
      end
    endcase
  end

  // Divide by 256 truncating toward zero (bias negatives before the floor
  // shift), then floor-shift by the normalisation and keep the low word.
  function automatic logic signed [DATA_W-1:0] f_norm(input logic signed [IW-1:0] x);
    logic signed [IW-1:0] q;
    if (x[IW-1]) q = (x + W_RND) >>> Q_SHIFT;
    else         q = x >>> Q_SHIFT;
    q = q >>> N_SHIFT;
    return q[DATA_W-1:0];
  endfunction

  assign o_top_re = f_norm((w_ar <<< Q_SHIFT) + w_wr);
  assign o_top_im = f_norm((w_ai <<< Q_SHIFT) + w_wi);
  assign o_bot_re = f_norm((w_ar <<< Q_SHIFT) - w_wr);
  assign o_bot_im = f_norm((w_ai <<< Q_SHIFT) - w_wi);

endmodule

// File: rtl/ifft_stage3_serializer.sv
// Final IFFT stage: captures an 8-point frame, runs the stage-3 butterflies, streams 8 samples.
// Latency: accept at E0, buffer loaded and first sample valid after E1; >=10 cycles per frame.
// Backpressure: out_ready low holds the current sample stable; in_ready is low until the frame drains.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            frame handshake from IFFT stage 2
//   ifft_dN_real/imag (N=1..8)   stage-2 outputs, position N-1
//   out_valid/out_ready          per-sample handshake to writeback
//   out_real/out_imag            current sample; out_idx its position; out_last at position 7
module ifft_stage3_serializer
  import ifft_stage3_serializer_pkg::*;
#(
  parameter int DATA_W = INST_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ifft_d1_real,
  input  logic [DATA_W-1:0] ifft_d1_imag,
  input  logic [DATA_W-1:0] ifft_d2_real,
  input  logic [DATA_W-1:0] ifft_d2_imag,
  input  logic [DATA_W-1:0] ifft_d3_real,
  input  logic [DATA_W-1:0] ifft_d3_imag,
  input  logic [DATA_W-1:0] ifft_d4_real,
  input  logic [DATA_W-1:0] ifft_d4_imag,
  input  logic [DATA_W-1:0] ifft_d5_real,
  input  logic [DATA_W-1:0] ifft_d5_imag,
  input  logic [DATA_W-1:0] ifft_d6_real,
  input  logic [DATA_W-1:0] ifft_d6_imag,
  input  logic [DATA_W-1:0] ifft_d7_real,
  input  logic [DATA_W-1:0] ifft_d7_imag,
  input  logic [DATA_W-1:0] ifft_d8_real,
  input  logic [DATA_W-1:0] ifft_d8_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [2:0]        out_idx,
  output logic              out_last
);

  state_t r_state, w_state_nxt;
  logic [2:0] r_idx;

  logic [DATA_W-1:0] w_in_re [8];
  logic [DATA_W-1:0] w_in_im [8];
  logic [DATA_W-1:0] r_in_re [8];
  logic [DATA_W-1:0] r_in_im [8];
  logic [DATA_W-1:0] r_buf_re [8];
  logic [DATA_W-1:0] r_buf_im [8];

  logic [DATA_W-1:0] w_top_re [4];
  logic [DATA_W-1:0] w_top_im [4];
  logic [DATA_W-1:0] w_bot_re [4];
  logic [DATA_W-1:0] w_bot_im [4];

  logic w_capture, w_load, w_advance;

  assign w_in_re[0] = ifft_d1_real;  assign w_in_im[0] = ifft_d1_imag;
  assign w_in_re[1] = ifft_d2_real;  assign w_in_im[1] = ifft_d2_imag;
  assign w_in_re[2] = ifft_d3_real;  assign w_in_im[2] = ifft_d3_imag;
  assign w_in_re[3] = ifft_d4_real;  assign w_in_im[3] = ifft_d4_imag;
  assign w_in_re[4] = ifft_d5_real;  assign w_in_im[4] = ifft_d5_imag;
  assign w_in_re[5] = ifft_d6_real;  assign w_in_im[5] = ifft_d6_imag;
  assign w_in_re[6] = ifft_d7_real;  assign w_in_im[6] = ifft_d7_imag;
  assign w_in_re[7] = ifft_d8_real;  assign w_in_im[7] = ifft_d8_imag;

  // Butterflies work from the captured frame, so stage-2 may change its
  // outputs freely once the accept edge has passed.
  for (genvar g = 0; g < 4; g++) begin : g_bfly
    ifft_bfly_pair #(.DATA_W(DATA_W)) u_bfly (
      .i_a_re   (r_in_re[g]),
      .i_a_im   (r_in_im[g]),
      .i_b_re   (r_in_re[g+4]),
      .i_b_im   (r_in_im[g+4]),
      .i_tw_sel (2'(g)),
      .o_top_re (w_top_re[g]),
      .o_top_im (w_top_im[g]),
      .o_bot_re (w_bot_re[g]),
      .o_bot_im (w_bot_im[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gate with rst so in_ready is low for the whole reset pulse.
        in_ready = !rst;
        if (in_valid && !rst) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_advance = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      for (int i = 0; i < 8; i++) begin
        r_in_re[i]  <= '0;
        r_in_im[i]  <= '0;
        r_buf_re[i] <= '0;
        r_buf_im[i] <= '0;
      end
    end else begin
      if (w_capture) begin
        for (int i = 0; i < 8; i++) begin
          r_in_re[i] <= w_in_re[i];
          r_in_im[i] <= w_in_im[i];
        end
      end
      if (w_load) begin
        for (int p = 0; p < 4; p++) begin
          r_buf_re[p]   <= w_top_re[p];
          r_buf_im[p]   <= w_top_im[p];
          r_buf_re[p+4] <= w_bot_re[p];
          r_buf_im[p+4] <= w_bot_im[p];
        end
        r_idx <= '0;
      end else if (w_advance) begin
        // Wraps 7 -> 0, leaving the index ready for the next frame.
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  assign out_idx  = r_idx;
  assign out_last = (r_idx == 3'd7);
  assign out_real = r_buf_re[r_idx];
  assign out_imag = r_buf_im[r_idx];

endmodule

// File: tb/tb_ifft_stage3_serializer.sv
// Self-checking bench for ifft_stage3_serializer: directed table, multi-cycle corners, random frames.
// Expected samples come from a complex-arithmetic reference model of the inverse butterfly.
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
module tb_ifft_stage3_serializer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] drv_re [8];
  logic [31:0] drv_im [8];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_real;
  logic [31:0] out_imag;
  logic [2:0]  out_idx;
  logic        out_last;

  logic [31:0] exp_re [8];
  logic [31:0] exp_im [8];
  logic [31:0] e16_re [16];
  logic [31:0] e16_im [16];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [2:0]        pos;
    logic              is_im;
    logic [31:0]       val;
    logic [7:0][31:0]  e_re;
    logic [7:0][31:0]  e_im;
  } vec_t;

  vec_t tbl [5];

  ifft_stage3_serializer #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ifft_d1_real (drv_re[0]), .ifft_d1_imag (drv_im[0]),
    .ifft_d2_real (drv_re[1]), .ifft_d2_imag (drv_im[1]),
    .ifft_d3_real (drv_re[2]), .ifft_d3_imag (drv_im[2]),
    .ifft_d4_real (drv_re[3]), .ifft_d4_imag (drv_im[3]),
    .ifft_d5_real (drv_re[4]), .ifft_d5_imag (drv_im[4]),
    .ifft_d6_real (drv_re[5]), .ifft_d6_imag (drv_im[5]),
    .ifft_d7_real (drv_re[6]), .ifft_d7_imag (drv_im[6]),
    .ifft_d8_real (drv_re[7]), .ifft_d8_imag (drv_im[7]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_real     (out_real),
    .out_imag     (out_imag),
    .out_idx      (out_idx),
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, $signed(act), $signed(want));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Twiddle w_k = exp(+j*pi*k/4) in Q8.
  function automatic longint tw_re(input int k);
    case (k)
      0: return 256;
      1: return 181;
      2: return 0;
      default: return -181;
    endcase
  endfunction

  function automatic longint tw_im(input int k);
    return (k == 0) ? 0 : (k == 2) ? 256 : 181;
  endfunction

  // x is a stage value at x256 scale: truncating divide by 256, then floor divide by 8.
  function automatic logic [31:0] norm(input longint x);
    longint q, r;
    q = x / 256;
    r = q / 8;
    if ((q % 8 != 0) && (q < 0)) r = r - 1;
    return r[31:0];
  endfunction

  task automatic model();
    longint ar, ai, br, bi, pr, pi;
    for (int p = 0; p < 4; p++) begin
      ar = longint'($signed(drv_re[p]));
      ai = longint'($signed(drv_im[p]));
      br = longint'($signed(drv_re[p+4]));
      bi = longint'($signed(drv_im[p+4]));
      pr = br * tw_re(p) - bi * tw_im(p);
      pi = br * tw_im(p) + bi * tw_re(p);
      exp_re[p]   = norm(ar * 256 + pr);
      exp_im[p]   = norm(ai * 256 + pi);
      exp_re[p+4] = norm(ar * 256 - pr);
      exp_im[p+4] = norm(ai * 256 - pi);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 8; i++) begin
      drv_re[i] = $urandom;
      drv_im[i] = $urandom;
    end
    model();
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame();
    int g;
    g = 0;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) chk("accept_timeout", 32'd1, 32'd0);
    step();
    in_valid = 1'b0;
    // Now in the compute cycle: nothing presented, nothing accepted.
    chk("calc_out_valid", 32'(out_valid), 32'd0);
    chk("calc_in_ready", 32'(in_ready), 32'd0);
    // Scribble the inputs; the captured frame must not change.
    for (int i = 0; i < 8; i++) begin
      drv_re[i] = $urandom;
      drv_im[i] = $urandom;
    end
  endtask

  // Collects the 8 beats of a frame against exp_*. Optionally stalls
  // 5 cycles at stall_at, or pulses reset when abort_at is presented.
  task automatic drain(input int stall_at, input int abort_at, input bit rnd);
    int got, guard, stalled;
    got = 0;
    guard = 0;
    stalled = 0;
    while (got < 8 && guard < 200) begin
      if (abort_at >= 0 && out_valid && out_idx == 3'(abort_at)) begin
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_idx", 32'(out_idx), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_out_real", out_real, 32'd0);
        chk("abort_out_last", 32'(out_last), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("abort_release_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        return;
      end
      if (stall_at >= 0 && out_valid && out_idx == 3'(stall_at) && stalled < 5) begin
        out_ready = 1'b0;
        stalled++;
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_out_idx", 32'(out_idx), 32'(stall_at));
        chk("stall_out_real", out_real, exp_re[stall_at]);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end else begin
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (out_valid && out_ready) begin
        chk("beat_idx", 32'(out_idx), 32'(got));
        chk("beat_real", out_real, exp_re[got]);
        chk("beat_imag", out_imag, exp_im[got]);
        chk("beat_last", 32'(out_last), 32'(got == 7));
        got++;
      end
      step();
      guard++;
    end
    if (got < 8) chk("drain_timeout", 32'(got), 32'd8);
    out_ready = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    int acc, nb, g, acc_cyc0, acc_cyc1;
    bit loaded;

    for (int t = 0; t < 5; t++) tbl[t] = '0;
    tbl[0].pos = 3'd0; tbl[0].is_im = 1'b0; tbl[0].val = 32'd800;
    tbl[0].e_re[0] = 32'd100; tbl[0].e_re[4] = 32'd100;
    tbl[1].pos = 3'd5; tbl[1].is_im = 1'b0; tbl[1].val = 32'd256;
    tbl[1].e_re[1] = 32'd22; tbl[1].e_im[1] = 32'd22;
    tbl[1].e_re[5] = -32'sd23; tbl[1].e_im[5] = -32'sd23;
    tbl[2].pos = 3'd6; tbl[2].is_im = 1'b1; tbl[2].val = 32'd80;
    tbl[2].e_re[2] = -32'sd10; tbl[2].e_re[6] = 32'd10;
    tbl[3].pos = 3'd7; tbl[3].is_im = 1'b0; tbl[3].val = 32'd256;
    tbl[3].e_re[3] = -32'sd23; tbl[3].e_im[3] = 32'd22;
    tbl[3].e_re[7] = 32'd22;   tbl[3].e_im[7] = -32'sd23;
    tbl[4].pos = 3'd1; tbl[4].is_im = 1'b1; tbl[4].val = -32'sd9;
    tbl[4].e_im[1] = -32'sd2; tbl[4].e_im[5] = -32'sd2;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drv_re[i] = '0;
      drv_im[i] = '0;
    end

    // Reset state.
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_real", out_real, 32'd0);
    chk("rst_out_imag", out_imag, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single-impulse vectors.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) begin
        drv_re[i] = '0;
        drv_im[i] = '0;
        exp_re[i] = tbl[t].e_re[i];
        exp_im[i] = tbl[t].e_im[i];
      end
      if (tbl[t].is_im) drv_im[tbl[t].pos] = tbl[t].val;
      else              drv_re[tbl[t].pos] = tbl[t].val;
      send_frame();
      drain(-1, -1, 1'b0);
    end

    // Backpressure held for 5 cycles at position 3.
    rand_frame();
    send_frame();
    drain(3, -1, 1'b0);

    // Reset mid-emission at position 5, then a fresh frame from position 0.
    rand_frame();
    send_frame();
    drain(-1, 5, 1'b0);
    rand_frame();
    send_frame();
    drain(-1, -1, 1'b0);

    // Two back-to-back frames with in_valid and out_ready held high.
    rand_frame();
    for (int i = 0; i < 8; i++) begin
      e16_re[i] = exp_re[i];
      e16_im[i] = exp_im[i];
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    acc = 0; nb = 0; g = 0; loaded = 1'b0;
    acc_cyc0 = 0; acc_cyc1 = 0;
    while (nb < 16 && g < 100) begin
      if (in_valid && in_ready) begin
        if (acc == 0) acc_cyc0 = cyc;
        else          acc_cyc1 = cyc;
        acc++;
      end
      if (out_valid && out_ready) begin
        chk("b2b_idx", 32'(out_idx), 32'(nb % 8));
        chk("b2b_real", out_real, e16_re[nb]);
        chk("b2b_imag", out_imag, e16_im[nb]);
        chk("b2b_last", 32'(out_last), 32'(nb % 8 == 7));
        nb++;
      end
      step();
      g++;
      if (acc == 1 && !loaded) begin
        rand_frame();
        for (int i = 0; i < 8; i++) begin
          e16_re[i+8] = exp_re[i];
          e16_im[i+8] = exp_im[i];
        end
        loaded = 1'b1;
      end
      if (acc == 2) in_valid = 1'b0;
    end
    chk("b2b_beats", 32'(nb), 32'd16);
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_accept_gap", 32'(acc_cyc1 - acc_cyc0), 32'd10);
    in_valid = 1'b0;

    // Random frames with random downstream stalls.
    for (int f = 0; f < 20; f++) begin
      rand_frame();
      send_frame();
      drain(-1, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
